// File: rtl/gpio_in_pkg.sv
// Shared types and defaults for the GPIO input capture path.
package gpio_in_pkg;

  typedef enum logic [1:0] {
    S_PRIME,
    S_LOAD,
    S_RUN
  } state_t;

  localparam int DEFAULT_DEBOUNCE    = 250;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/gpio_in_bit.sv
// One GPIO input pin: synchroniser, optional debounce, level register and sticky edge event.
module gpio_in_bit
  import gpio_in_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  input  logic debounce_en,
  input  logic rise_en,
  input  logic fall_en,
  input  logic clear,
  input  logic load,
  input  logic run,
  output logic level,
  output logic evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  logic                   level_p1;
  logic                   set_evt;

  assign s = sync_p0[SYNC_STAGES-1];

  // level_p1 trails level by one cycle, so an edge is seen the cycle after level moves
  assign set_evt = run & ((level & ~level_p1 & rise_en) | (~level & level_p1 & fall_en));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0  <= '0;
      cnt      <= '0;
      level    <= 1'b0;
      level_p1 <= 1'b0;
      evt      <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pin};
      evt     <= set_evt | (evt & ~clear);
      if (load) begin
        // Seeding both copies keeps the first run cycle from seeing a fake edge
        level    <= s;
        level_p1 <= s;
        cnt      <= '0;
      end else begin
        level_p1 <= level;
        if (run) begin
          if (!debounce_en) begin
            level <= s;
            cnt   <= '0;
          end else if (s == level) begin
            cnt <= '0;
          end else if (cnt >= CNT_LAST) begin
            level <= s;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/gpio_in_capture.sv
// GPIO bank input conditioner: priming FSM, per-pin capture instances and interrupt reduction.
module gpio_in_capture
  import gpio_in_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_i,
  input  logic [WIDTH-1:0] debounce_en_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] irq_mask_i,
  input  logic [WIDTH-1:0] clear_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] event_o,
  output logic             irq_o,
  output logic             ready_o
);

  localparam int PRIME_W = 3;
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES);

  state_t               state;
  logic [PRIME_W-1:0]   prime_cnt;
  logic                 load;
  logic                 run;

  assign load = (state == S_LOAD);
  assign run  = (state == S_RUN);

  // Priming waits until the synchronisers hold real pin values before loading level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_PRIME;
      prime_cnt <= '0;
      ready_o   <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      irq_o <= |(event_o & irq_mask_i);
      case (state)
        S_PRIME: begin
          if (prime_cnt == PRIME_LAST) state <= S_LOAD;
          else                         prime_cnt <= prime_cnt + PRIME_W'(1);
        end
        S_LOAD: begin
          state   <= S_RUN;
          ready_o <= 1'b1;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_in_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .pin        (pin_i[i]),
      .debounce_en(debounce_en_i[i]),
      .rise_en    (rise_en_i[i]),
      .fall_en    (fall_en_i[i]),
      .clear      (clear_i[i]),
      .load       (load),
      .run        (run),
      .level      (level_o[i]),
      .evt        (event_o[i])
    );
  end

endmodule

// File: tb/tb_gpio_in_capture.sv
// Bench for gpio_in_capture: directed scenarios with literal expectations plus a randomized run against a behavioural model.
module tb_gpio_in_capture;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int DEB   = 250;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] pin_i = 32'hFFFF_0000;
  logic [WIDTH-1:0] debounce_en_i = '0;
  logic [WIDTH-1:0] rise_en_i = '0;
  logic [WIDTH-1:0] fall_en_i = '0;
  logic [WIDTH-1:0] irq_mask_i = '0;
  logic [WIDTH-1:0] clear_i = '0;
  logic [WIDTH-1:0] level_o;
  logic [WIDTH-1:0] event_o;
  logic             irq_o;
  logic             ready_o;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  gpio_in_capture #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pin_i        (pin_i),
    .debounce_en_i(debounce_en_i),
    .rise_en_i    (rise_en_i),
    .fall_en_i    (fall_en_i),
    .irq_mask_i   (irq_mask_i),
    .clear_i      (clear_i),
    .level_o      (level_o),
    .event_o      (event_o),
    .irq_o        (irq_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pin history, cycles since reset release, run length of disagreement
  logic [WIDTH-1:0] m_hist [SYNC];
  int               m_ncyc;
  logic [WIDTH-1:0] m_level, m_prev, m_evt;
  logic             m_irq, m_ready;
  int               m_run [WIDTH];

  logic [WIDTH-1:0] t_s, t_level, t_evt;
  bit               t_load, t_run;
  int               t_len [WIDTH];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC; k++) m_hist[k] <= '0;
      for (int i = 0; i < WIDTH; i++) m_run[i] <= 0;
      m_ncyc  <= 0;
      m_level <= '0;
      m_prev  <= '0;
      m_evt   <= '0;
      m_irq   <= 1'b0;
      m_ready <= 1'b0;
    end else begin
      t_s    = m_hist[SYNC-1];
      t_load = (m_ncyc == SYNC + 1);
      t_run  = (m_ncyc >= SYNC + 2);
      t_level = m_level;
      for (int i = 0; i < WIDTH; i++) t_len[i] = m_run[i];
      if (t_load) begin
        t_level = t_s;
      end else if (t_run) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (!debounce_en_i[i]) begin
            t_level[i] = t_s[i];
            t_len[i]   = 0;
          end else if (t_s[i] != m_level[i]) begin
            t_len[i] = t_len[i] + 1;
            if (t_len[i] >= DEB) begin
              t_level[i] = t_s[i];
              t_len[i]   = 0;
            end
          end else begin
            t_len[i] = 0;
          end
        end
      end
      t_evt = m_evt & ~clear_i;
      if (t_run) t_evt = t_evt | (m_level & ~m_prev & rise_en_i) | (~m_level & m_prev & fall_en_i);
      for (int k = SYNC - 1; k > 0; k--) m_hist[k] <= m_hist[k-1];
      m_hist[0] <= pin_i;
      for (int i = 0; i < WIDTH; i++) m_run[i] <= t_len[i];
      m_prev  <= t_load ? t_s : m_level;
      m_level <= t_level;
      m_evt   <= t_evt;
      m_irq   <= |(m_evt & irq_mask_i);
      m_ready <= (m_ncyc >= SYNC + 1);
      m_ncyc  <= (m_ncyc < 100000) ? m_ncyc + 1 : m_ncyc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_level", level_o, m_level);
      check("model_event", event_o, m_evt);
      check("model_irq", {31'b0, irq_o}, {31'b0, m_irq});
      check("model_ready", {31'b0, ready_o}, {31'b0, m_ready});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset with upper half of the bank high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    reset_n = 1'b1;
    for (int k = 1; k <= SYNC + 2; k++) begin
      step(1);
      check("ready_after_release", {31'b0, ready_o}, (k == SYNC + 2) ? 32'd1 : 32'd0);
    end
    check("reset_level", level_o, 32'hFFFF_0000);
    check("reset_model_level", m_level, 32'hFFFF_0000);
    check("reset_event", event_o, 32'h0);
    check("reset_irq", {31'b0, irq_o}, 32'd0);

    // Bypass rising edge on pin0 through to irq, then clear
    rise_en_i[0] = 1'b1;
    irq_mask_i[0] = 1'b1;
    pin_i[0] = 1'b1;
    step(2);
    check("p0_level_+2", {31'b0, level_o[0]}, 32'd0);
    step(1);
    check("p0_level_+3", {31'b0, level_o[0]}, 32'd1);
    check("p0_event_+3", {31'b0, event_o[0]}, 32'd0);
    step(1);
    check("p0_event_+4", {31'b0, event_o[0]}, 32'd1);
    check("p0_irq_+4", {31'b0, irq_o}, 32'd0);
    step(1);
    check("p0_irq_+5", {31'b0, irq_o}, 32'd1);
    clear_i[0] = 1'b1;
    step(1);
    clear_i[0] = 1'b0;
    check("p0_event_cleared", {31'b0, event_o[0]}, 32'd0);
    step(1);
    check("p0_irq_cleared", {31'b0, irq_o}, 32'd0);

    // Debounced pin3: 100-cycle glitch rejected, then a held level accepted after 250 cycles
    debounce_en_i[3] = 1'b1;
    rise_en_i[3] = 1'b1;
    pin_i[3] = 1'b1;
    step(100);
    pin_i[3] = 1'b0;
    step(10);
    check("p3_glitch_level", {31'b0, level_o[3]}, 32'd0);
    check("p3_glitch_event", {31'b0, event_o[3]}, 32'd0);
    pin_i[3] = 1'b1;
    step(SYNC + DEB - 1);
    check("p3_level_before", {31'b0, level_o[3]}, 32'd0);
    step(1);
    check("p3_level_at_250", {31'b0, level_o[3]}, 32'd1);
    step(1);
    check("p3_event", {31'b0, event_o[3]}, 32'd1);
    step(300 - SYNC - DEB - 1);
    clear_i = '1;
    step(1);
    clear_i = '0;

    // Fall-only capture on pin5
    fall_en_i[5] = 1'b1;
    pin_i[5] = 1'b1;
    step(6);
    check("p5_no_rise_event", {31'b0, event_o[5]}, 32'd0);
    pin_i[5] = 1'b0;
    step(6);
    check("p5_fall_event", {31'b0, event_o[5]}, 32'd1);
    clear_i[5] = 1'b1;
    step(1);
    clear_i[5] = 1'b0;
    pin_i[5] = 1'b1;
    step(6);
    check("p5_rise_ignored", {31'b0, event_o[5]}, 32'd0);

    // Clear and set arriving in the same cycle on pin7
    rise_en_i[7] = 1'b1;
    pin_i[7] = 1'b1;
    step(SYNC + 1);
    clear_i[7] = 1'b1;
    step(1);
    clear_i[7] = 1'b0;
    check("p7_set_beats_clear", {31'b0, event_o[7]}, 32'd1);
    clear_i = '1;
    step(1);
    clear_i = '0;

    // Reset in the middle of a debounce count on pin3
    pin_i[3] = 1'b0;
    step(SYNC + 120);
    #2 reset_n = 1'b0;
    #1;
    check("rst_level", level_o, 32'h0);
    check("rst_event", event_o, 32'h0);
    check("rst_irq", {31'b0, irq_o}, 32'd0);
    check("rst_ready", {31'b0, ready_o}, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(SYNC + 2);
    check("reprime_ready", {31'b0, ready_o}, 32'd1);
    check("reprime_level", level_o, pin_i);
    check("reprime_event", event_o, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        debounce_en_i = $urandom & $urandom;
        rise_en_i     = $urandom;
        fall_en_i     = $urandom;
        irq_mask_i    = $urandom;
      end
      if ($urandom_range(0, 3) == 0) pin_i = pin_i ^ ($urandom & $urandom & $urandom);
      clear_i = $urandom & $urandom & $urandom;
      step(1);
    end
    clear_i = '0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
